// File: rtl/inv_pipe.sv
// inv_pipe: registered invert/pass/XOR-mask stage with DEPTH pipeline
// registers, valid/ready flow control and a wrapping delivered-word counter.
// The transform is applied when a word is accepted. The stages only store
// and forward the result.
module inv_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    MODE_INV  = 2'd0,
    MODE_PASS = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] r;
  logic [WIDTH-1:0] fa;

  // Word transform applied at acceptance; the reserved code behaves as invert
  always_comb begin
    case (mode_e'(mode))
      MODE_PASS: fa = a;
      MODE_XOR:  fa = a ^ mask;
      default:   fa = ~a;
    endcase
  end

  // Stage k may load when it or any stage downstream of it is empty, or when
  // the consumer takes y. This is the unrolled form of the ready chain
  // r[k] = ~v[k] | r[k+1]. It avoids a self-referencing combinational vector.
  always_comb begin
    r = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      r[k] = y_ready;
      for (int unsigned j = k; j < DEPTH; j++) begin
        if (!v[j]) r[k] = 1'b1;
      end
    end
  end

  assign a_ready = r[0];
  assign y       = d[DEPTH-1];
  assign y_valid = v[DEPTH-1];

  // Pipeline stages: a ready stage loads from upstream, otherwise it holds
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) d[k] <= '0;
    end else begin
      if (r[0]) begin
        d[0] <= fa;
        v[0] <= a_valid;
      end
      for (int unsigned k = 1; k < DEPTH; k++) begin
        if (r[k]) begin
          d[k] <= d[k-1];
          v[k] <= v[k-1];
        end
      end
    end
  end

  // Delivered-word counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) xfer_cnt <= '0;
    else if (y_valid && y_ready) xfer_cnt <= xfer_cnt + 1'b1;
  end

endmodule
